// File: rtl/vram_sprite_line_reader.sv
// vram_sprite_line_reader: fetches one 256-bit sprite line from VRAM and streams
// it out as 32 8-bit pixels over a valid/ready handshake.
// Optional feature: define VRAM_SPRITE_READER_FLIP_EN to honour req_flip_h
// (horizontal mirror, output pixel k = line byte 31-k).
module vram_sprite_line_reader #(
    parameter int unsigned READ_LATENCY = 1,
    parameter int unsigned PIXEL_W      = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [5:0]         req_sprite,
    input  logic [4:0]         req_row,
    input  logic               req_flip_h,
    output logic [11:0]        read_addr,
    input  logic [255:0]       read_data,
    output logic               pix_valid,
    input  logic               pix_ready,
    output logic [PIXEL_W-1:0] pix_data,
    output logic               pix_last
);

    localparam int unsigned LINE_W  = 256;
    localparam int unsigned NUM_PIX = LINE_W / PIXEL_W;
    localparam int unsigned IDX_W   = 5;
    localparam int unsigned CNT_W   = 3;
    localparam int unsigned ADDR_W  = 12;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        STREAM = 2'd2
    } state_t;

    state_t              state;
    logic [IDX_W-1:0]    idx;
    logic [CNT_W-1:0]    cnt;
    logic [LINE_W-1:0]   line_buf;
    logic [IDX_W-1:0]    idx_next;

`ifdef VRAM_SPRITE_READER_FLIP_EN
    logic flip;
`else
    localparam logic flip = 1'b0;
    logic flip_h_unused;
    assign flip_h_unused = req_flip_h;
`endif

    // Buffer byte shown for output position i; mirroring reads byte 31-i (= ~i).
    function automatic logic [PIXEL_W-1:0] pixel_at(input logic [LINE_W-1:0] line_v,
                                                    input logic [IDX_W-1:0]  i,
                                                    input logic              mirror);
        logic [IDX_W-1:0] sel;
        sel = mirror ? ~i : i;
        return line_v[32'(sel) * PIXEL_W +: PIXEL_W];
    endfunction

    assign idx_next = idx + IDX_W'(1);

    // Request accept, VRAM fetch wait and pixel streaming.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            req_ready <= 1'b0;
            read_addr <= '0;
            pix_valid <= 1'b0;
            pix_data  <= '0;
            pix_last  <= 1'b0;
            idx       <= '0;
            cnt       <= '0;
            line_buf  <= '0;
`ifdef VRAM_SPRITE_READER_FLIP_EN
            flip      <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    req_ready <= 1'b1;
                    if (req_valid && req_ready) begin
                        read_addr <= ADDR_W'({req_sprite, req_row});
`ifdef VRAM_SPRITE_READER_FLIP_EN
                        flip      <= req_flip_h;
`endif
                        req_ready <= 1'b0;
                        cnt       <= CNT_W'(READ_LATENCY);
                        state     <= FETCH;
                    end
                end

                FETCH: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_W'(1);
                        // counter hits zero on this edge: line data is valid now
                        if (cnt == CNT_W'(1)) begin
                            line_buf <= read_data;
                        end
                    end else begin
                        state     <= STREAM;
                        idx       <= '0;
                        pix_valid <= 1'b1;
                        pix_data  <= pixel_at(line_buf, '0, flip);
                        pix_last  <= 1'b0;
                    end
                end

                STREAM: begin
                    if (pix_ready) begin
                        if (idx == IDX_W'(NUM_PIX - 1)) begin
                            pix_valid <= 1'b0;
                            pix_last  <= 1'b0;
                            idx       <= '0;
                            req_ready <= 1'b1;
                            state     <= IDLE;
                        end else begin
                            idx      <= idx_next;
                            pix_data <= pixel_at(line_buf, idx_next, flip);
                            pix_last <= (idx_next == IDX_W'(NUM_PIX - 1));
                        end
                    end
                end

                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b0;
                    pix_valid <= 1'b0;
                    pix_last  <= 1'b0;
                    idx       <= '0;
                end
            endcase
        end
    end

endmodule

// File: doc/vram_sprite_line_reader.md
Name: vram_sprite_line_reader

Overview:
- Read-side client of the sprite VRAM: turns a (sprite, row) request into a 12-bit line address, waits for the 256-bit line and streams it out as 32 8-bit pixels, one per handshake.
- The 256-bit line holds the 16 16-bit pixel pairs written by the VRAM write port.
- Sits between the sprite VRAM read port and the scanline compositor.

Parameters:
- READ_LATENCY, 1, clock cycles from read_addr driven to read_data valid at the VRAM (legal 1..4).
- PIXEL_W, 8, bits per pixel (fixed at 8; 32 pixels per 256-bit line).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  1  line request present.
- req_ready  output  1  block can accept a request.
- req_sprite  input  6  sprite index 0..63.
- req_row  input  5  row within 32-row sprite.
- req_flip_h  input  1  horizontal mirror request (see Optional Feature).
- read_addr  output  12  VRAM line address = {req_sprite, req_row}.
- read_data  input  256  VRAM line data.
- pix_valid  output  1  pix_data valid.
- pix_ready  input  1  consumer accepts pixel.
- pix_data  output  8  current pixel.
- pix_last  output  1  high with pixel 31 of the line.

Behaviour:
- Reset (async, rst_n low): state IDLE; req_ready=0, read_addr=0, pix_valid=0, pix_data=0, pix_last=0, pixel index=0, latency counter=0, line buffer=0. Outputs go to reset values immediately on rst_n low, not at the next edge.
- req_ready is registered. It rises on the first clk edge after rst_n deasserts.
- States: IDLE, FETCH, STREAM.
- IDLE:
  - req_ready=1.
  - On req_valid&&req_ready: register read_addr={req_sprite,req_row}, latch the flip flag, clear req_ready, load counter=READ_LATENCY, go to FETCH.
- FETCH:
  - Decrement counter each cycle.
  - When the counter reaches 0, capture read_data into the 256-bit line buffer. This happens exactly READ_LATENCY cycles after the cycle read_addr was first driven.
  - Next cycle: go to STREAM with index=0 and pix_valid=1.
- read_addr holds stable from accept until capture. It keeps its value afterwards (no return to 0).
- STREAM:
  - pix_data = buffer byte [8*i+7 : 8*i], where i = index.
  - Pixel 0 is bits [7:0], which is the low byte of pair address 16*line.
  - On pix_valid&&pix_ready, index increments.
  - pix_data and pix_last are registered and held stable while pix_ready=0.
  - pix_last=1 exactly when index=31.
- End of line: the handshake on index 31 gives pix_valid=0, pix_last=0, index=0, state IDLE and req_ready=1, all on the same edge. A new request is accepted no earlier than the following cycle.
- Latency: request accepted at edge T → first pixel valid at edge T+READ_LATENCY+1 (T+2 for default).
- Throughput: with pix_ready held high, 32 pixels on 32 consecutive cycles. Line-to-line gap is READ_LATENCY+2 cycles.
- Index is 5 bits and wraps 31→0 only via the end-of-line transition.
- req_valid while req_ready=0 is ignored. The requester must hold its request until accepted.
- Reset asserted mid-FETCH or mid-STREAM aborts the line with no partial output after release. The next request restarts cleanly.

Optional Feature:
- Macro: VRAM_SPRITE_READER_FLIP_EN.
- Defined: the latched req_flip_h=1 reverses output order, so output pixel k = buffer byte 31-k. pix_last is still asserted on the 32nd output pixel.
- Undefined: req_flip_h is ignored (port present, unconnected internally) and the order is always byte 0..31.

Test Plan:
- Reset, then request sprite=5, row=3 → read_addr=0x0A3; with a VRAM model loaded with byte n = line[7:0]^n, pix_data sequence is 0xA3^0..0xA3^31; first pix_valid 2 cycles after accept; pix_last only on the 32nd pixel.
- pix_ready toggled 1,0,0,1,… during a stream → pix_data/pix_last stable during stalls; exactly 32 handshakes; req_ready rises after the 32nd.
- Back-to-back requests for lines 0x000 and 0xFFF with pix_ready=1 → 64 pixels; gap of READ_LATENCY+2 cycles between last and next first pixel; read_addr=0xFFF for the second.
- READ_LATENCY=3 build → capture occurs 3 cycles after read_addr changes; first pixel 4 cycles after accept; data matches the model.
- rst_n pulsed low at pixel 10 → pix_valid=0 immediately; req_ready=0 until the first edge after release; a following request for line 0x010 streams all 32 correct pixels.
- VRAM_SPRITE_READER_FLIP_EN defined, req_flip_h=1 on line 0x0A3 → sequence 0xA3^31 down to 0xA3^0. The same stimulus with the macro undefined gives ascending order.
